// File: rtl/note_detector.sv
// Tone-period note detector: synchronizes a square-wave tone, measures the spacing of its
// rising edges and locks onto one of eight piano notes after two agreeing periods.
module note_detector #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TIMEOUT = 524_288
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        tone_in,
    output logic [3:0]  note,
    output logic        valid,
    output logic        note_change,
    output logic [7:0]  Led,
    output logic [19:0] period
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_CONFIRM = 2'd2;
    localparam logic [1:0] S_LOCK    = 2'd3;

    localparam logic [19:0] CNT_MAX = 20'hF_FFFF;

    function automatic logic [19:0] nominal(input longint unsigned hz, input longint unsigned centi_hz);
        longint unsigned q;
        q = (hz * 64'd100) / centi_hz;
        return q[19:0];
    endfunction

    // Index k holds the nominal period of note code k (C4 .. C5)
    localparam logic [8:1][19:0] NOM = {
        nominal(64'(CLK_HZ), 64'd52325), nominal(64'(CLK_HZ), 64'd49388),
        nominal(64'(CLK_HZ), 64'd44000), nominal(64'(CLK_HZ), 64'd39200),
        nominal(64'(CLK_HZ), 64'd34923), nominal(64'(CLK_HZ), 64'd32963),
        nominal(64'(CLK_HZ), 64'd29366), nominal(64'(CLK_HZ), 64'd26163)
    };

    logic        sync1_q, sync2_q, prev_q, edge_q;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] period_q, period_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  note_q, note_d;
    logic        valid_q, chg_q;
    logic [7:0]  led_q, led_d;
    logic [3:0]  cls;
    logic        timeout;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    // cnt_q is the number of clocks since the previous edge pulse, so its value on the
    // edge cycle is exactly the edge spacing.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (edge_q) begin
            cnt_d    = 20'd1;
            period_d = cnt_q;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 20'd1;
        end
    end

    always_comb begin
        logic [20:0] lo, hi, p;
        cls = 4'd0;
        p   = {1'b0, cnt_q};
        for (int k = 1; k <= 8; k++) begin
            lo = {1'b0, NOM[k]} - {1'b0, NOM[k] >> 6};
            hi = {1'b0, NOM[k]} + {1'b0, NOM[k] >> 6};
            if (p >= lo && p <= hi) cls = 4'(k);
        end
    end

    assign timeout = ({12'd0, cnt_q} >= 32'(TIMEOUT));

    // An edge always wins over a simultaneous timeout
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        note_d  = note_q;
        if (edge_q) begin
            case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM: begin
                    if (cls != 4'd0) begin
                        cand_d  = cls;
                        state_d = S_CONFIRM;
                    end
                end
                S_CONFIRM: begin
                    if (cls == 4'd0) begin
                        state_d = S_ARM;
                    end else if (cls == cand_q) begin
                        state_d = S_LOCK;
                        note_d  = cand_q;
                    end else begin
                        cand_d = cls;
                    end
                end
                default: begin
                    if (cls == note_q) begin
                        state_d = S_LOCK;
                    end else if (cls != 4'd0) begin
                        cand_d  = cls;
                        state_d = S_CONFIRM;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            endcase
        end else if (state_q != S_IDLE && timeout) begin
            state_d = S_IDLE;
            note_d  = 4'd0;
        end
    end

    always_comb begin
        led_d = 8'h00;
        if (note_d >= 4'd1 && note_d <= 4'd8) led_d = 8'h80 >> (note_d - 4'd1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q    <= 20'd0;
            period_q <= 20'd0;
            state_q  <= S_IDLE;
            cand_q   <= 4'd0;
            note_q   <= 4'd0;
            valid_q  <= 1'b0;
            chg_q    <= 1'b0;
            led_q    <= 8'h00;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            note_q   <= note_d;
            valid_q  <= (note_d != 4'd0);
            chg_q    <= (note_d != note_q);
            led_q    <= led_d;
        end
    end

    assign note        = note_q;
    assign valid       = valid_q;
    assign note_change = chg_q;
    assign Led         = led_q;
    assign period      = period_q;

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector at a scaled-down clock rate; note_change pulses are
// checked by a monitor against a queue of expected notes filled by the stimulus process.
module tb_note_detector;

    localparam int unsigned CLK_HZ  = 500_000;
    localparam int unsigned TIMEOUT = 4000;
    localparam int H = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tone = 1'b0;
    logic [3:0]  note;
    logic        valid;
    logic        chg;
    logic [7:0]  led;
    logic [19:0] period;

    typedef struct {
        logic [3:0] note;
        logic [7:0] led;
    } exp_t;

    exp_t expq[$];
    int n_chk = 0;
    int n_pass = 0;
    int n_pulse = 0;

    note_detector #(.CLK_HZ(CLK_HZ), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .RESET(rst), .tone_in(tone), .note(note), .valid(valid),
        .note_change(chg), .Led(led), .period(period)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rising edge lands exactly p clocks after the previous call's rising edge
    task automatic edge_after(input int p);
        tone = 1'b0;
        cycles(p - H);
        tone = 1'b1;
        cycles(H);
    endtask

    task automatic edges(input int n, input int p);
        repeat (n) edge_after(p);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && chg) begin
            n_pulse++;
            if (expq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pulse: got pulse with note %0d expected no pulse", note);
            end else begin
                e = expq.pop_front();
                check("pulse_note", int'(note), int'(e.note));
                check("pulse_led", int'(led), int'(e.led));
                check("pulse_valid", int'(valid), int'(e.note != 4'd0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int k;
        cycles(3);
        check("rst_note", int'(note), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_led", int'(led), 0);
        check("rst_chg", int'(chg), 0);
        check("rst_period", int'(period), 0);
        rst = 1'b0;

        // A4 lock needs three edges
        expq.push_back('{4'd6, 8'h04});
        edge_after(1136);
        check("a_edge1_note", int'(note), 0);
        edge_after(1136);
        check("a_edge2_note", int'(note), 0);
        edge_after(1136);
        check("a_note", int'(note), 6);
        check("a_valid", int'(valid), 1);
        check("a_led", int'(led), 8'h04);
        check("a_period", int'(period), 1136);
        check("a_pulses", n_pulse, 1);

        // Switch to B
        expq.push_back('{4'd7, 8'h02});
        edge_after(1012);
        check("b_edge1_note", int'(note), 6);
        check("b_period", int'(period), 1012);
        edge_after(1012);
        check("b_note", int'(note), 7);
        check("b_led", int'(led), 8'h02);
        check("b_pulses", n_pulse, 2);

        // C4 then timeout
        expq.push_back('{4'd1, 8'h80});
        edges(2, 1911);
        check("c4_note", int'(note), 1);
        check("c4_led", int'(led), 8'h80);
        expq.push_back('{4'd0, 8'h00});
        tone = 1'b0;
        cycles(TIMEOUT - 200);
        check("to_before", int'(note), 1);
        k = 0;
        while (note != 4'd0 && k < 400) begin
            cycles(1);
            k++;
        end
        check("to_note", int'(note), 0);
        check("to_led", int'(led), 0);
        check("to_valid", int'(valid), 0);
        cycles(5000);
        check("idle_pulses", n_pulse, 4);

        // Out of every window
        edges(3, 750);
        check("oow_note", int'(note), 0);
        check("oow_valid", int'(valid), 0);
        check("oow_period", int'(period), 750);
        check("oow_pulses", n_pulse, 4);

        // C5 window boundaries: 955 +/- 14
        edges(3, 970);
        check("c5_hi_out_note", int'(note), 0);
        check("c5_hi_out_period", int'(period), 970);
        edges(2, 940);
        check("c5_lo_out_note", int'(note), 0);
        expq.push_back('{4'd8, 8'h01});
        edges(2, 969);
        check("c5_note", int'(note), 8);
        check("c5_led", int'(led), 8'h01);
        check("c5_period", int'(period), 969);

        // G lock, then reset mid-lock
        expq.push_back('{4'd5, 8'h08});
        edges(2, 1275);
        check("g_note", int'(note), 5);
        check("g_pulses", n_pulse, 6);
        tone = 1'b0;
        cycles(10);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("mrst_note", int'(note), 0);
        check("mrst_valid", int'(valid), 0);
        check("mrst_led", int'(led), 0);
        check("mrst_chg", int'(chg), 0);
        check("mrst_period", int'(period), 0);
        cycles(2);
        check("mrst_pulses", n_pulse, 6);

        expq.push_back('{4'd5, 8'h08});
        edge_after(1275);
        check("relock_e1", int'(note), 0);
        edge_after(1275);
        check("relock_e2", int'(note), 0);
        edge_after(1275);
        check("relock_note", int'(note), 5);
        check("relock_valid", int'(valid), 1);
        check("relock_pulses", n_pulse, 7);
        check("queue_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
